// File: rtl/alu_arbiter_41.sv
// Round-robin arbiter granting one of four requesters the shared ALU result path.
// Optional hold timeout compiled in with `define ALU_ARB_TIMEOUT_EN.
module alu_arbiter_41 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("alu_arbiter_41: MAX_HOLD must be in 2..255");
  end

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       rel_normal;

  // Scan from the farthest offset down so the requester closest to ptr_q wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // While granted, sel_q is the owner's index, so it addresses its handshake bits.
  assign rel_normal = done[sel_q] | ~req[sel_q];

`ifdef ALU_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q;
  logic       timeout_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
`ifdef ALU_ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ALU_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_GRANT;
            gnt_q   <= 4'b0001 << pick_idx;
            sel_q   <= pick_idx;
`ifdef ALU_ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
`endif
          end
        end
        ST_GRANT: begin
          if (rel_normal) begin
            state_q <= ST_RELEASE;
            gnt_q   <= 4'b0000;
            ptr_q   <= sel_q + 2'd1;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          // A normal exit in the final allowed cycle wins, so no timeout is flagged.
          else if (hold_q == HOLD_LAST) begin
            state_q   <= ST_RELEASE;
            gnt_q     <= 4'b0000;
            ptr_q     <= sel_q + 2'd1;
            timeout_q <= 1'b1;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q != ST_IDLE);

`ifdef ALU_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter_41.sv
// Self-checking bench for alu_arbiter_41: ownership-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_alu_arbiter_41;

  localparam int MAX_HOLD = 8;
`ifdef ALU_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  alu_arbiter_41 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the ALU, whether we are in the single cooldown
  // cycle, how many cycles the owner has held it, and where the next search starts.
  int m_owner = -1;
  bit m_cool  = 1'b0;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_last  = 0;
  bit m_to    = 1'b0;

  task automatic model_revoke(input bit forced);
    m_ptr   = (m_owner + 1) % 4;
    m_owner = -1;
    m_cool  = 1'b1;
    m_to    = forced;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_cool = 1'b0; m_held = 0; m_ptr = 0; m_last = 0; m_to = 1'b0;
      end else if (m_cool) begin
        m_cool = 1'b0;
        m_to   = 1'b0;
      end else if (m_owner < 0) begin
        for (int i = 0; i < 4; i++) begin
          if (m_owner < 0 && req[(m_ptr + i) % 4]) begin
            m_owner = (m_ptr + i) % 4;
            m_last  = m_owner;
            m_held  = 1;
          end
        end
      end else if (done[m_owner] || !req[m_owner]) begin
        model_revoke(1'b0);
      end else if (TIMEOUT_ON && m_held == MAX_HOLD) begin
        model_revoke(1'b1);
      end else begin
        m_held++;
      end
    end
  end

  initial begin
    logic [3:0] exp_gnt;
    forever begin
      @(negedge clk);
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check("cyc_gnt", {28'd0, gnt}, {28'd0, exp_gnt});
      check("cyc_sel", {30'd0, sel}, m_last);
      check("cyc_busy", {31'd0, busy}, {31'd0, (m_owner >= 0) || m_cool});
      check("cyc_timeout", {31'd0, timeout}, {31'd0, m_to});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] e;
    int cnt;

    rst_n = 1'b0; req = 4'b0000; done = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {28'd0, gnt}, 32'h0);
    check("rst_sel", {30'd0, sel}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_timeout", {31'd0, timeout}, 32'h0);
    rst_n = 1'b1;

    // Single requester 2, done and req drop together.
    req = 4'b0100;
    tick();
    check("a_gnt", {28'd0, gnt}, 32'h4);
    check("a_sel", {30'd0, sel}, 32'd2);
    check("a_busy", {31'd0, busy}, 32'h1);
    done = 4'b0100; req = 4'b0000;
    tick();
    check("a_rel_gnt", {28'd0, gnt}, 32'h0);
    check("a_rel_busy", {31'd0, busy}, 32'h1);
    done = 4'b0000;
    tick();
    check("a_idle_busy", {31'd0, busy}, 32'h0);
    check("a_idle_sel", {30'd0, sel}, 32'd2);
    req = 4'b1111;
    tick();
    check("a_ptr3_gnt", {28'd0, gnt}, 32'h8);

    // Asynchronous reset mid-grant.
    rst_n = 1'b0;
    #1;
    check("e_rst_gnt", {28'd0, gnt}, 32'h0);
    check("e_rst_sel", {30'd0, sel}, 32'h0);
    check("e_rst_busy", {31'd0, busy}, 32'h0);
    req = 4'b0110;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("e_gnt", {28'd0, gnt}, 32'h2);
    check("e_sel", {30'd0, sel}, 32'd1);
    req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // All requesting: rotation 0,1,2,3,0.
    req = 4'b1111;
    foreach (order[i]) begin
      e = 4'b0001 << order[i];
      tick();
      check("b_gnt", {28'd0, gnt}, {28'd0, e});
      check("b_sel", {30'd0, sel}, order[i]);
      done = e;
      tick();
      check("b_rel_gnt", {28'd0, gnt}, 32'h0);
      done = 4'b0000;
      tick();
      check("b_idle_gnt", {28'd0, gnt}, 32'h0);
    end

    // Requester 3 drops req, pointer wraps to 0.
    req = 4'b1000;
    tick();
    check("c_gnt3", {28'd0, gnt}, 32'h8);
    req = 4'b0000;
    tick();
    tick();
    req = 4'b1001;
    tick();
    check("c_wrap_gnt", {28'd0, gnt}, 32'h1);
    check("c_wrap_sel", {30'd0, sel}, 32'd0);

    // Foreign done/req activity is ignored while 1 holds the grant.
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0010;
    tick();
    check("d_gnt", {28'd0, gnt}, 32'h2);
    done = 4'b0101; req = 4'b1011;
    tick();
    check("d_hold_gnt", {28'd0, gnt}, 32'h2);
    check("d_hold_sel", {30'd0, sel}, 32'd1);
    tick();
    check("d_hold2_gnt", {28'd0, gnt}, 32'h2);
    done = 4'b0000; req = 4'b0000;
    tick();
    tick();

    // Long hold with no done.
    req = 4'b0001;
    tick();
    cnt = 0;
    while (gnt == 4'b0001 && cnt < 120) begin
      cnt++;
      tick();
    end
`ifdef ALU_ARB_TIMEOUT_EN
    check("f_hold_cycles", cnt, MAX_HOLD);
    check("f_timeout_pulse", {31'd0, timeout}, 32'h1);
    check("f_timeout_gnt", {28'd0, gnt}, 32'h0);
    tick();
    check("f_timeout_clear", {31'd0, timeout}, 32'h0);
    tick();
    check("f_regrant", {28'd0, gnt}, 32'h1);
    repeat (MAX_HOLD - 1) tick();
    done = 4'b0001;
    tick();
    check("f_tie_gnt", {28'd0, gnt}, 32'h0);
    check("f_tie_timeout", {31'd0, timeout}, 32'h0);
    done = 4'b0000;
`else
    check("f_hold_cycles", cnt, 120);
    check("f_still_gnt", {28'd0, gnt}, 32'h1);
    check("f_no_timeout", {31'd0, timeout}, 32'h0);
`endif
    req = 4'b0000;
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
